afifo_rd_stream: RTL and testbench



---
 rtl/afifo_rd_stream_if.sv | 30 +++
 rtl/afifo_rd_stream.sv | 87 ++++++++
 tb/tb_afifo_rd_stream.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_stream_if.sv
// Signal bundle between afifo_rd_stream and its neighbours: afifo pull port,
// downstream valid/ready stream, status counters and occupancy taps.
interface afifo_rd_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int OCC_WIDTH  = 2
);
    logic                  ff_empty;
    logic [DATA_WIDTH-1:0] ff_dout;
    logic                  ff_rd_ack;
    logic                  ff_rd_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic                  err_ack;
    logic [OCC_WIDTH-1:0]  dbg_occ;
    logic                  dbg_inflight;

    // Stream handshake: a word moves on every Clk edge with out_valid && out_ready;
    // once out_valid is high, out_valid/out_data hold until that transfer, Flush or Reset.
    modport master (
        input  ff_empty, ff_dout, ff_rd_ack, out_ready,
        output ff_rd_en, out_data, out_valid, word_cnt, err_ack, dbg_occ, dbg_inflight
    );
    modport slave (
        output ff_empty, ff_dout, ff_rd_ack, out_ready,
        input  ff_rd_en, out_data, out_valid, word_cnt, err_ack, dbg_occ, dbg_inflight
    );
endinterface

// File: rtl/afifo_rd_stream.sv
// Read-side consumer for afifo: converts the registered pull port into a
// valid/ready stream through a small skid buffer, counts words, flags stray acks.
module afifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    afifo_rd_stream_if.master bus
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [OCC_W:0]   DEPTH_P  = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_O  = OCC_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      occ;
    logic                  inflight;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic                  err_ack;
    logic [OCC_W:0]        pending;
    logic                  pop;
    logic                  cap;
    logic                  rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A read may be issued into the last free slot only if a pop frees one this cycle.
    always_comb begin
        pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        pop     = (occ != '0) && bus.out_ready;
        cap     = bus.ff_rd_ack && inflight && !Flush;
        rd_en   = !Reset && !Flush && !bus.ff_empty &&
                  ((pending < DEPTH_P) || ((pending == DEPTH_P) && pop));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            word_cnt <= '0;
            err_ack  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            inflight <= rd_en;
            if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
            if (bus.ff_rd_ack && !inflight) err_ack <= 1'b1;
            if (Flush) begin
                // an ack landing in the flush cycle belongs to a discarded read
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (cap) begin
                    mem[tail] <= bus.ff_dout;
                    tail      <= next_ptr(tail);
                end
                if (pop) head <= next_ptr(head);
                case ({cap, pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Capture into a full buffer without a pop would lose a word; the issue rule forbids it.
    assert property (@(posedge Clk) disable iff (Reset) !(cap && (occ == DEPTH_O) && !pop));

    assign bus.ff_rd_en     = rd_en;
    assign bus.out_valid    = (occ != '0);
    assign bus.out_data     = mem[head];
    assign bus.word_cnt     = word_cnt;
    assign bus.err_ack      = err_ack;
    assign bus.dbg_occ      = occ;
    assign bus.dbg_inflight = inflight;
endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: emulated afifo source, queue-based reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_afifo_rd_stream;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = 16;
    localparam int OW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic Reset;
    logic Flush;

    afifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .OCC_WIDTH(OW)) bus ();

    afifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .Clk   (clk),
        .Reset (Reset),
        .Flush (Flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 50)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: buffer as a queue of words ----------------
    logic [DW-1:0] exp_q[$];
    bit            m_infl      = 1'b0;
    bit            m_err       = 1'b0;
    bit            m_zero_data = 1'b1;
    logic [CW-1:0] m_cnt       = '0;

    always @(negedge clk) begin : model
        bit exp_v;
        bit exp_rd;
        bit pop;
        int pend;
        exp_v  = (exp_q.size() > 0);
        pend   = exp_q.size() + int'(m_infl);
        pop    = exp_v && bus.out_ready;
        exp_rd = !Reset && !Flush && !bus.ff_empty &&
                 ((pend < DEPTH) || ((pend == DEPTH) && pop));
        check("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        else if (m_zero_data) check("out_data_rst", 32'(bus.out_data), 32'd0);
        check("ff_rd_en", 32'(bus.ff_rd_en), 32'(exp_rd));
        check("word_cnt", 32'(bus.word_cnt), 32'(m_cnt));
        check("err_ack", 32'(bus.err_ack), 32'(m_err));
        check("occ", 32'(bus.dbg_occ), 32'(exp_q.size()));
        check("inflight", 32'(bus.dbg_inflight), 32'(m_infl));
        if (Reset) begin
            exp_q.delete();
            m_infl      = 1'b0;
            m_err       = 1'b0;
            m_cnt       = '0;
            m_zero_data = 1'b1;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (bus.ff_rd_ack && !m_infl) m_err = 1'b1;
            if (Flush) exp_q.delete();
            else if (bus.ff_rd_ack && m_infl) begin
                exp_q.push_back(bus.ff_dout);
                m_zero_data = 1'b0;
            end
            m_infl = exp_rd;
        end
    end

    // ---------------- afifo emulation and monitor (main process) ----------------
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] got_q[$];
    bit            rd_en_s   = 1'b0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int cyc = 0, rd_pulses = 0, beats = 0, valid_cycles = 0;
    int first_v = -1, last_v = -1, fall_c = -1;

    task automatic clear_mon();
        got_q.delete();
        rd_pulses = 0; beats = 0; valid_cycles = 0;
        first_v = -1; last_v = -1; fall_c = -1;
    endtask

    task automatic step(input bit rs, input bit fl, input bit rdy, input bit spur);
        @(posedge clk);
        #1;
        if (rd_en_s && !bus.ff_empty) begin
            bus.ff_rd_ack = 1'b1;
            bus.ff_dout   = src_q.pop_front();
        end else begin
            bus.ff_rd_ack = spur;
            bus.ff_dout   = DW'($urandom);
        end
        if (rs) src_q.delete();
        bus.ff_empty  = (src_q.size() == 0);
        Reset         = rs;
        Flush         = fl;
        bus.out_ready = rdy;
        @(negedge clk);
        #1;
        if (hold_prev) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'(prev_data));
        end
        hold_prev = bus.out_valid && !bus.out_ready && !Reset && !Flush;
        prev_data = bus.out_data;
        rd_en_s   = bus.ff_rd_en;
        if (bus.ff_rd_en) rd_pulses++;
        if (bus.out_valid) begin
            valid_cycles++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            beats++;
        end
        if (!bus.ff_empty && fall_c < 0) fall_c = cyc;
        cyc++;
    endtask

    task automatic run(input int n, input bit rdy);
        repeat (n) step(1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic check_got(input string name, input logic [DW-1:0] base, input int n);
        check({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            check(name, 32'(got_q[i]), 32'(base + DW'(i)));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "time limit");
    end

    initial begin : main
        int guard;
        Reset = 1'b1; Flush = 1'b0;
        bus.out_ready = 1'b0; bus.ff_empty = 1'b1;
        bus.ff_rd_ack = 1'b0; bus.ff_dout = '0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_cnt", 32'(bus.word_cnt), 32'd0);
        check("rst_err", 32'(bus.err_ack), 32'd0);
        check("rst_rd_en", 32'(bus.ff_rd_en), 32'd0);

        // 8 preloaded words, always ready
        step(1'b0, 1'b0, 1'b1, 1'b0);
        clear_mon();
        for (int w = 1; w <= 8; w++) src_q.push_back(DW'(w));
        run(14, 1'b1);
        check_got("t1_data", 16'h0001, 8);
        check("t1_latency", 32'(first_v - fall_c), 32'd2);
        check("t1_valid_cycles", 32'(valid_cycles), 32'd8);
        check("t1_contiguous", 32'(last_v - first_v), 32'd7);
        check("t1_word_cnt", 32'(bus.word_cnt), 32'd8);

        // same words, ready pattern 1,0,0,1
        clear_mon();
        for (int w = 1; w <= 8; w++) src_q.push_back(DW'(w));
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
        check_got("t2_data", 16'h0001, 8);
        check("t2_word_cnt", 32'(bus.word_cnt), 32'd16);

        // single word, source empties right after
        clear_mon();
        src_q.push_back(16'hA5A5);
        run(8, 1'b1);
        check("t3_rd_pulses", 32'(rd_pulses), 32'd1);
        check("t3_beats", 32'(beats), 32'd1);
        check_got("t3_data", 16'hA5A5, 1);
        check("t3_valid_after", 32'(bus.out_valid), 32'd0);
        check("t3_occ_after", 32'(bus.dbg_occ), 32'd0);

        // stray ack with nothing in flight
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_err_set", 32'(bus.err_ack), 32'd1);
        clear_mon();
        for (int w = 0; w < 3; w++) src_q.push_back(16'h0B01 + DW'(w));
        run(8, 1'b1);
        check_got("t4_stream", 16'h0B01, 3);
        check("t4_err_sticky", 32'(bus.err_ack), 32'd1);

        // reset mid-burst
        for (int w = 0; w < 6; w++) src_q.push_back(16'h0C00 + DW'(w));
        run(4, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_valid", 32'(bus.out_valid), 32'd0);
        check("t6_data", 32'(bus.out_data), 32'd0);
        check("t6_cnt", 32'(bus.word_cnt), 32'd0);
        check("t6_err", 32'(bus.err_ack), 32'd0);
        check("t6_occ", 32'(bus.dbg_occ), 32'd0);
        check("t6_rd_en", 32'(bus.ff_rd_en), 32'd0);

        // flush while a read is in flight and a word is buffered
        clear_mon();
        for (int w = 0; w < 4; w++) src_q.push_back(16'h0010 + DW'(w));
        run(4, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_err", 32'(bus.err_ack), 32'd0);
        run(8, 1'b1);
        check("t5_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("t5_first", 32'(got_q[0]), 32'h0010);
            check("t5_after", 32'(got_q[1]), 32'h0013);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0 && src_q.size() < 5) src_q.push_back(DW'($urandom));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 149) == 0);
        end

        // counter wrap
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        clear_mon();
        guard = 0;
        while (beats < 65535 && guard < 70000) begin
            if (src_q.size() < 4) src_q.push_back(DW'(guard));
            step(1'b0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        check("wrap_reach", 32'(beats), 32'd65535);
        run(4, 1'b0);
        check("wrap_ffff", 32'(bus.word_cnt), 32'h0000FFFF);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_beats", 32'(beats), 32'd65536);
        check("wrap_zero", 32'(bus.word_cnt), 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
